iter_shift_unit: RTL and testbench
==================================

# iter_shift_unit

Parametrised, multi-cycle shift/rotate unit for the ALU. It is the sequential successor to the single-cycle combinational right shifter. It supports four shift modes and saturating shift amounts, and reports carry-out and zero flags. It shifts one bit position per clock, trading latency for area, and talks to the ALU issue/writeback logic through valid/ready handshakes on both sides.

## Interface
- WIDTH, 8: operand/result width; legal values are 2 or more.
- SHAMT_W, 5: shift-amount width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous and active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request (high only in IDLE).
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  unsigned shift amount.
- in_mode  input  2  shift mode: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  last bit shifted or rotated out; 0 if effective amount is 0.
- out_zero  output  1  out_data equals 0.

## Operation
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, at the clock edge: load in_data into the data register, latch the mode, compute cnt, clear carry, and go to SHIFT.
- Effective amount cnt:
  - Rotate: in_shamt mod WIDTH.
  - Other modes: min(in_shamt, WIDTH).
  - Counter width is clog2(WIDTH+1).
- SHIFT:
  - If cnt>0, perform one 1-bit step per clock and decrement cnt.
  - If cnt==0, go to DONE; the data is not modified on that edge.
- One-bit step, by mode:
  - Logical left: data={data[W-2:0],0}, carry=data[W-1].
  - Logical right: data={0,data[W-1:1]}, carry=data[0].
  - Arithmetic right: data={data[W-1],data[W-1:1]}, carry=data[0].
  - Rotate right: data={data[0],data[W-1:1]}, carry=data[0].
- Saturation results: logical shifts with in_shamt>=WIDTH yield 0; arithmetic right with in_shamt>=WIDTH yields all copies of the sign bit. Both follow naturally from WIDTH steps.
- DONE:
  - out_valid=1.
  - out_data, out_carry and out_zero are held stable.
  - On out_ready, go to IDLE.
- No overlap: a new request is accepted only in IDLE, at the earliest the cycle after the DONE handshake.
- in_data, in_shamt and in_mode are sampled only at the accept edge. Later changes have no effect.
- out_zero is derived combinationally from the data register. out_data is the data register.

## Timing
- Reset (rst_n=0 at a clock edge) puts the unit in IDLE and sets:
  - in_ready=1, out_valid=0.
  - out_data=0, out_carry=0, out_zero=1.
  - cnt=0.
- Reset mid-operation, in SHIFT or DONE, discards the operation. Outputs take their reset values on that edge. No result is produced.
- Latency: out_valid rises cnt+1 clock edges after the accept edge. The range is 1 (cnt=0) to WIDTH+1.
- Throughput: one request per cnt+3 cycles at best, with out_ready held high.
- Backpressure: DONE persists indefinitely while out_ready=0. in_ready stays 0 throughout.
- in_valid while busy is ignored. The requester must hold the request until in_ready, per valid/ready rules.
- in_ready and out_valid are pure functions of state, with no combinational path from in_valid or out_ready.

## Test plan
- Logical right, WIDTH=8, in_data=0x96, shamt=3 -> out_data=0x12, carry=1, zero=0; out_valid 4 cycles after accept.
- Arithmetic right, in_data=0x96, shamt=20 (saturates to 8) -> out_data=0xFF, carry=1; latency 9.
- Rotate right, in_data=0x96, shamt=11 (eff 3) -> out_data=0xD2, carry=1; latency 4.
- Logical left:
  - in_data=0x96, shamt=0 -> out_data=0x96, carry=0; latency 1.
  - in_data=0x81, shamt=8 -> out_data=0x00, zero=1, carry=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data is stable, in_ready=0, and a pulsed in_valid is not accepted. Then raise out_ready -> IDLE next cycle, and a new request is accepted.
- Reset: assert rst_n=0 during SHIFT of an 8-step job -> the next cycle shows IDLE, in_ready=1, out_valid=0, out_data=0. A back-to-back new request completes correctly.

Source files
------------

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: one bit position per clock, valid/ready on both sides.
// Supports logical left/right, arithmetic right and rotate right, with carry and zero flags.
module iter_shift_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               out_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [1:0]       mode_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic [CW-1:0]    cnt_load;
    logic [WIDTH-1:0] step_data;
    logic             step_carry;

    // Rotation wraps modulo WIDTH; shifts saturate at WIDTH steps.
    always_comb begin
        cnt_load = '0;
        if (in_mode == 2'b11)
            cnt_load = CW'(32'(in_shamt) % 32'(WIDTH));
        else if (32'(in_shamt) >= 32'(WIDTH))
            cnt_load = CW'(WIDTH);
        else
            cnt_load = CW'(in_shamt);
    end

    always_comb begin
        step_data  = data_reg;
        step_carry = data_reg[0];
        case (mode_reg)
            2'b00: begin
                step_data  = {data_reg[WIDTH-2:0], 1'b0};
                step_carry = data_reg[WIDTH-1];
            end
            2'b01:   step_data = {1'b0, data_reg[WIDTH-1:1]};
            2'b10:   step_data = {data_reg[WIDTH-1], data_reg[WIDTH-1:1]};
            default: step_data = {data_reg[0], data_reg[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            mode_reg      <= 2'b00;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg     <= in_data;
                        mode_reg     <= in_mode;
                        cnt_reg      <= cnt_load;
                        carry_reg    <= 1'b0;
                        state_reg    <= SHIFT;
                        in_ready_reg <= 1'b0;
                    end
                end
                SHIFT: begin
                    // The cnt==0 edge only moves to DONE, leaving data untouched.
                    if (cnt_reg != '0) begin
                        data_reg  <= step_data;
                        carry_reg <= step_carry;
                        cnt_reg   <= cnt_reg - CW'(1);
                    end else begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = data_reg;
    assign out_carry = carry_reg;
    assign out_zero  = (data_reg == '0);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Bench for iter_shift_unit: directed vectors plus random requests checked every
// cycle against a transaction-level model built from plain shift arithmetic.
module tb_iter_shift_unit;
    localparam int W  = 8;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [SW-1:0] in_shamt = '0;
    logic [1:0]    in_mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          out_carry;
    logic          out_zero;

    int tests = 0;
    int fails = 0;

    iter_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operation result computed directly from the amount, not step by step.
    function automatic void model(input logic [W-1:0] d, input int s, input int m,
                                  output logic [W-1:0] r, output logic c, output int eff);
        eff = (m == 3) ? (s % W) : ((s > W) ? W : s);
        r = d;
        c = 1'b0;
        if (eff > 0) begin
            case (m)
                0: begin r = d << eff;             c = d[W-eff]; end
                1: begin r = d >> eff;             c = d[eff-1]; end
                2: begin r = $signed(d) >>> eff;   c = d[eff-1]; end
                default: begin r = (d >> eff) | (d << (W - eff)); c = d[eff-1]; end
            endcase
        end
    endfunction

    // Cycle-level expectation: idle / busy countdown / result-held.
    logic         m_started = 1'b0;
    logic         m_idle = 1'b1;
    logic         m_valid = 1'b0;
    logic         m_clean = 1'b1;
    int           m_left = 0;
    int           m_eff = 0;
    logic [W-1:0] m_data = '0;
    logic         m_carry = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_started = 1'b1;
            m_idle    = 1'b1;
            m_valid   = 1'b0;
            m_clean   = 1'b1;
            m_left    = 0;
        end else if (m_idle) begin
            if (in_valid) begin
                model(in_data, int'(in_shamt), int'(in_mode), m_data, m_carry, m_eff);
                m_idle  = 1'b0;
                m_clean = 1'b0;
                m_left  = m_eff + 1;
            end
        end else if (!m_valid) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready", 32'(in_ready), 32'(m_idle));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("out_data", 32'(out_data), 32'(m_data));
                chk("out_carry", 32'(out_carry), 32'(m_carry));
                chk("out_zero", 32'(out_zero), 32'(m_data == '0));
            end else if (m_clean) begin
                chk("rst_data", 32'(out_data), 32'h0);
                chk("rst_carry", 32'(out_carry), 32'h0);
                chk("rst_zero", 32'(out_zero), 32'h1);
            end
        end
    end

    // One request; lit_lat < 0 means no hand-computed literals for this one.
    task automatic run(input logic [W-1:0] d, input int s, input int m, input int hold,
                       input logic pulse, input int lit_lat, input int lit_data,
                       input int lit_carry, input int lit_zero);
        logic [W-1:0] r;
        logic         c;
        int           eff;
        int           guard;
        int           lat;
        logic [W-1:0] got_d;
        logic         got_c;
        logic         got_z;
        model(d, s, m, r, c, eff);
        out_ready = (hold == 0);
        in_data   = d;
        in_shamt  = SW'(s);
        in_mode   = 2'(m);
        in_valid  = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'h1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_shamt = SW'($urandom);
        in_mode  = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(eff + 1));
        got_d = out_data;
        got_c = out_carry;
        got_z = out_zero;
        if (lit_lat >= 0) begin
            chk("lit_latency", 32'(lat), 32'(lit_lat));
            chk("lit_data", 32'(got_d), 32'(lit_data));
            chk("lit_carry", 32'(got_c), 32'(lit_carry));
            chk("lit_zero", 32'(got_z), 32'(lit_zero));
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = pulse && (i == 1);
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_hold_data", 32'(out_data), 32'(got_d));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        $display("[TB] txn mode=%0d data=%02h shamt=%0d -> out=%02h carry=%0b zero=%0b lat=%0d hold=%0d",
                 m, d, s, got_d, got_c, got_z, lat, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_zero", 32'(out_zero), 32'h1);

        run(8'h96, 3, 1, 0, 1'b0, 4, 'h12, 1, 0);
        run(8'h96, 20, 2, 0, 1'b0, 9, 'hFF, 1, 0);
        run(8'h96, 11, 3, 0, 1'b0, 4, 'hD2, 1, 0);
        run(8'h96, 0, 0, 0, 1'b0, 1, 'h96, 0, 0);
        run(8'h81, 8, 0, 0, 1'b0, 9, 'h00, 1, 1);
        run(8'h5A, 2, 1, 5, 1'b1, 3, 'h16, 1, 0);
        run(8'h3C, 4, 3, 0, 1'b0, 5, 'hC3, 1, 0);

        // Reset in the middle of an 8-step job.
        out_ready = 1'b1;
        in_data   = 8'h81;
        in_shamt  = SW'(8);
        in_mode   = 2'b00;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_data", 32'(out_data), 32'h0);
        run(8'h96, 3, 1, 0, 1'b0, 4, 'h12, 1, 0);

        for (int k = 0; k < 60; k++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(posedge clk);
            #1;
            run(W'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), 1'($urandom), -1, 0, 0, 0);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
